// File: rtl/ahb2apb_rr_arbiter.sv
// ============================================================================
// Module   : ahb2apb_rr_arbiter
// Brief    : N AHB5 subordinate ports sharing one APB requester, round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahb2apb_rr_arbiter #(
    parameter  int NUM_AHB    = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 16,
    localparam int GW         = (NUM_AHB > 1) ? $clog2(NUM_AHB) : 1
) (
    input  logic                                 HCLK,
    input  logic                                 HRESETn,
    input  logic [NUM_AHB-1:0]                   HSEL,
    input  logic [NUM_AHB-1:0][1:0]              HTRANS,
    input  logic [NUM_AHB-1:0][ADDR_WIDTH-1:0]   HADDR,
    input  logic [NUM_AHB-1:0]                   HWRITE,
    input  logic [NUM_AHB-1:0][DATA_WIDTH-1:0]   HWDATA,
    output logic [NUM_AHB-1:0]                   HREADYOUT,
    output logic [NUM_AHB-1:0]                   HRESP,
    output logic [NUM_AHB-1:0][DATA_WIDTH-1:0]   HRDATA,
    output logic [ADDR_WIDTH-1:0]                PADDR,
    output logic [DATA_WIDTH-1:0]                PWDATA,
    output logic                                 PWRITE,
    output logic                                 PSEL,
    output logic                                 PENABLE,
    input  logic [DATA_WIDTH-1:0]                PRDATA,
    input  logic                                 PREADY,
    input  logic                                 PSLVERROR,
    output logic [GW-1:0]                        grant_id
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]                           state_q,  state_d;
    logic [GW-1:0]                        grant_q,  grant_d;
    logic [GW-1:0]                        last_q,   last_d;
    logic [CW-1:0]                        cnt_q,    cnt_d;
    logic [NUM_AHB-1:0]                   pend_q,   pend_d;
    logic [NUM_AHB-1:0]                   dph_q,    dph_d;
    logic [NUM_AHB-1:0]                   err1_q,   err1_d;
    logic [NUM_AHB-1:0]                   hready_q, hready_d;
    logic [NUM_AHB-1:0]                   hresp_q,  hresp_d;
    logic [NUM_AHB-1:0]                   write_q,  write_d;
    logic [NUM_AHB-1:0][ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [NUM_AHB-1:0][DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [NUM_AHB-1:0][DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic [ADDR_WIDTH-1:0]                paddr_q,  paddr_d;
    logic [DATA_WIDTH-1:0]                pwdata_q, pwdata_d;
    logic                                 pwrite_q, pwrite_d;

    logic          w_found;
    logic [GW-1:0] w_pick;
    logic          w_timeout;
    logic          w_ok;
    logic          w_err;
    logic          unused_htrans;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign unused_htrans = ^HTRANS;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_AHB; k++) begin
            idx = (int'(last_q) + k) % NUM_AHB;
            if (!w_found && pend_q[idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(idx);
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !PREADY &&
                       (cnt_q == CW'(TIMEOUT - 1));
    assign w_ok      = (state_q == ST_ACCESS) && PREADY && !PSLVERROR;
    assign w_err     = (state_q == ST_ACCESS) && ((PREADY && PSLVERROR) || w_timeout);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d  = ST_SETUP;
                    grant_d  = w_pick;
                    last_d   = w_pick;
                    paddr_d  = addr_q[w_pick];
                    pwrite_d = write_q[w_pick];
                    // A port granted in its data-phase cycle has not latched HWDATA yet.
                    pwdata_d = dph_q[w_pick] ? HWDATA[w_pick] : wdata_q[w_pick];
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (PREADY || w_timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        logic own;
        own      = 1'b0;
        pend_d   = pend_q;
        dph_d    = '0;
        err1_d   = err1_q;
        hready_d = hready_q;
        hresp_d  = hresp_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hrdata_d = hrdata_q;
        for (int i = 0; i < NUM_AHB; i++) begin
            own = (grant_q == GW'(i));
            if (dph_q[i]) begin
                wdata_d[i] = HWDATA[i];
            end
            if (HSEL[i] && HTRANS[i][1] && hready_q[i]) begin
                pend_d[i]   = 1'b1;
                dph_d[i]    = 1'b1;
                addr_d[i]   = HADDR[i];
                write_d[i]  = HWRITE[i];
                hready_d[i] = 1'b0;
                hresp_d[i]  = 1'b0;
            end else if (own && w_ok) begin
                pend_d[i]   = 1'b0;
                hready_d[i] = 1'b1;
                hresp_d[i]  = 1'b0;
                if (!pwrite_q) begin
                    hrdata_d[i] = PRDATA;
                end
            end else if (own && w_err) begin
                pend_d[i]   = 1'b0;
                err1_d[i]   = 1'b1;
                hready_d[i] = 1'b0;
                hresp_d[i]  = 1'b1;
            end else if (err1_q[i]) begin
                err1_d[i]   = 1'b0;
                hready_d[i] = 1'b1;
                hresp_d[i]  = 1'b1;
            end else if (hready_q[i]) begin
                hresp_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NUM_AHB - 1);
            cnt_q    <= '0;
            pend_q   <= '0;
            dph_q    <= '0;
            err1_q   <= '0;
            hready_q <= '1;
            hresp_q  <= '0;
            write_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hrdata_q <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            dph_q    <= dph_d;
            err1_q   <= err1_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hrdata_q <= hrdata_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
        end
    end

    assign PSEL      = (state_q != ST_IDLE);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign grant_id  = grant_q;
    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_rr_arbiter.sv
// ============================================================================
// Module   : tb_ahb2apb_rr_arbiter
// Brief    : Directed self-checking bench for ahb2apb_rr_arbiter (2 ports).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ahb2apb_rr_arbiter;

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b1;
    logic [1:0]        HSEL;
    logic [1:0][1:0]   HTRANS;
    logic [1:0][31:0]  HADDR;
    logic [1:0]        HWRITE;
    logic [1:0][31:0]  HWDATA;
    logic [1:0]        HREADYOUT;
    logic [1:0]        HRESP;
    logic [1:0][31:0]  HRDATA;
    logic [31:0]       PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERROR;
    logic [0:0]        grant_id;

    int npass  = 0;
    int ntotal = 0;
    int n;

    ahb2apb_rr_arbiter #(
        .NUM_AHB(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERROR(PSLVERROR), .grant_id(grant_id)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HSEL = '0; HTRANS = '0; HADDR = '0; HWRITE = '0; HWDATA = '0;
        PRDATA = '0; PREADY = 1'b1; PSLVERROR = 1'b0;
        #1 HRESETn = 1'b0;
        #2;
        check("rst_psel",    PSEL,      1'b0);
        check("rst_penable", PENABLE,   1'b0);
        check("rst_hready",  HREADYOUT, 2'b11);
        check("rst_hresp",   HRESP,     2'b00);
        check("rst_grant",   grant_id,  1'b0);
        check("rst_paddr",   PADDR,     32'h0);
        check("rst_pwdata",  PWDATA,    32'h0);
        @(posedge HCLK); @(posedge HCLK);
        #3 HRESETn = 1'b1;
        tick;

        // Port 0 write 0x10 <= A5A5A5A5, zero-wait APB
        HSEL[0] = 1'b1; HTRANS[0] = 2'b10; HADDR[0] = 32'h10; HWRITE[0] = 1'b1;
        tick;
        check("w0_dph_hready", HREADYOUT[0], 1'b0);
        check("w0_dph_psel",   PSEL,         1'b0);
        HSEL = '0; HTRANS = '0; HWDATA[0] = 32'hA5A5_A5A5;
        tick;
        check("w0_setup_psel",    PSEL,         1'b1);
        check("w0_setup_penable", PENABLE,      1'b0);
        check("w0_setup_paddr",   PADDR,        32'h10);
        check("w0_setup_pwdata",  PWDATA,       32'hA5A5_A5A5);
        check("w0_setup_pwrite",  PWRITE,       1'b1);
        check("w0_setup_grant",   grant_id,     1'b0);
        check("w0_setup_hready",  HREADYOUT[0], 1'b0);
        HWDATA[0] = 32'h0;
        tick;
        check("w0_access_penable", PENABLE,      1'b1);
        check("w0_access_pwdata",  PWDATA,       32'hA5A5_A5A5);
        check("w0_access_hready",  HREADYOUT[0], 1'b0);
        tick;
        check("w0_done_psel",   PSEL,         1'b0);
        check("w0_done_hready", HREADYOUT[0], 1'b1);
        check("w0_done_hresp",  HRESP[0],     1'b0);

        // Port 1 read 0x20 returning 12345678
        HSEL[1] = 1'b1; HTRANS[1] = 2'b10; HADDR[1] = 32'h20; HWRITE[1] = 1'b0;
        tick;
        HSEL = '0; HTRANS = '0; PRDATA = 32'h1234_5678;
        tick;
        check("r1_setup_grant",  grant_id, 1'b1);
        check("r1_setup_pwrite", PWRITE,   1'b0);
        check("r1_setup_paddr",  PADDR,    32'h20);
        tick;
        check("r1_access_hready", HREADYOUT[1], 1'b0);
        tick;
        check("r1_done_hready", HREADYOUT[1], 1'b1);
        check("r1_done_hrdata", HRDATA[1],    32'h1234_5678);
        check("r1_hrdata0",     HRDATA[0],    32'h0);
        PRDATA = 32'h0;

        // Simultaneous writes, two rounds: always 0 then 1
        for (int r = 0; r < 2; r++) begin
            HSEL = 2'b11; HTRANS[0] = 2'b10; HTRANS[1] = 2'b11; HWRITE = 2'b11;
            HADDR[0] = 32'h100 + r; HADDR[1] = 32'h200 + r;
            tick;
            HSEL = '0; HTRANS = '0;
            HWDATA[0] = 32'h1111_0000 + r; HWDATA[1] = 32'h2222_0000 + r;
            tick;
            check("rr_first_grant",  grant_id, 1'b0);
            check("rr_first_paddr",  PADDR,    32'h100 + r);
            check("rr_first_pwdata", PWDATA,   32'h1111_0000 + r);
            HWDATA = '0;
            tick;
            tick;
            check("rr_first_done_hready", HREADYOUT, 2'b01);
            check("rr_first_done_psel",   PSEL,      1'b0);
            tick;
            check("rr_second_grant",  grant_id,  1'b1);
            check("rr_second_psel",   PSEL,      1'b1);
            check("rr_second_paddr",  PADDR,     32'h200 + r);
            check("rr_second_pwdata", PWDATA,    32'h2222_0000 + r);
            check("rr_second_hready", HREADYOUT, 2'b01);
            tick;
            tick;
            check("rr_second_done_hready", HREADYOUT, 2'b11);
        end

        // Port 0 write answered with PSLVERROR, then read accepted in ERROR cycle 2
        HSEL[0] = 1'b1; HTRANS[0] = 2'b10; HADDR[0] = 32'h60; HWRITE[0] = 1'b1;
        tick;
        HSEL = '0; HTRANS = '0; HWDATA[0] = 32'hDEAD_BEEF;
        tick;
        tick;
        PSLVERROR = 1'b1;
        tick;
        check("err_c1_hready", HREADYOUT[0], 1'b0);
        check("err_c1_hresp",  HRESP[0],     1'b1);
        check("err_c1_psel",   PSEL,         1'b0);
        check("err_c1_hrdata", HRDATA[0],    32'h0);
        PSLVERROR = 1'b0;
        tick;
        check("err_c2_hready", HREADYOUT[0], 1'b1);
        check("err_c2_hresp",  HRESP[0],     1'b1);
        HSEL[0] = 1'b1; HTRANS[0] = 2'b10; HADDR[0] = 32'h30; HWRITE[0] = 1'b0;
        tick;
        check("err_next_hready", HREADYOUT[0], 1'b0);
        check("err_next_hresp",  HRESP[0],     1'b0);
        HSEL = '0; HTRANS = '0; PRDATA = 32'hCAFE_F00D;
        tick;
        check("err_next_grant", grant_id, 1'b0);
        check("err_next_paddr", PADDR,    32'h30);
        tick;
        tick;
        check("err_next_done_hready", HREADYOUT[0], 1'b1);
        check("err_next_done_hrdata", HRDATA[0],    32'hCAFE_F00D);
        check("err_next_done_hresp",  HRESP[0],     1'b0);
        PRDATA = 32'h0;

        // Port 1 write with PREADY stuck low: 16 ACCESS cycles then ERROR
        PREADY = 1'b0;
        HSEL[1] = 1'b1; HTRANS[1] = 2'b10; HADDR[1] = 32'h40; HWRITE[1] = 1'b1;
        tick;
        HSEL = '0; HTRANS = '0; HWDATA[1] = 32'h4444_4444;
        tick;
        check("to_setup_grant", grant_id, 1'b1);
        tick;
        check("to_access_penable", PENABLE, 1'b1);
        n = 0;
        for (int k = 0; k < 40 && PSEL; k++) begin
            n++;
            tick;
        end
        check("to_access_cycles", n,            16);
        check("to_c1_hready",     HREADYOUT[1], 1'b0);
        check("to_c1_hresp",      HRESP[1],     1'b1);
        tick;
        check("to_c2_hready", HREADYOUT[1], 1'b1);
        check("to_c2_hresp",  HRESP[1],     1'b1);
        tick;
        check("to_after_hresp", HRESP[1], 1'b0);

        // Reset during port 0 ACCESS; afterwards port 0 wins again
        HSEL[0] = 1'b1; HTRANS[0] = 2'b10; HADDR[0] = 32'h50; HWRITE[0] = 1'b1;
        tick;
        HSEL = '0; HTRANS = '0; HWDATA[0] = 32'h5555_5555;
        tick;
        tick;
        check("rst_mid_penable", PENABLE, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        check("rst_mid_psel",   PSEL,      1'b0);
        check("rst_mid_hready", HREADYOUT, 2'b11);
        check("rst_mid_hresp",  HRESP,     2'b00);
        check("rst_mid_hrdata", HRDATA,    64'h0);
        check("rst_mid_paddr",  PADDR,     32'h0);
        #2 HRESETn = 1'b1;
        PREADY = 1'b1;
        tick;
        check("rst_post_hready", HREADYOUT, 2'b11);
        check("rst_post_psel",   PSEL,      1'b0);
        HSEL = 2'b11; HTRANS[0] = 2'b10; HTRANS[1] = 2'b10; HWRITE = 2'b11;
        HADDR[0] = 32'h700; HADDR[1] = 32'h800;
        tick;
        HSEL = '0; HTRANS = '0; HWDATA[0] = 32'h7; HWDATA[1] = 32'h8;
        tick;
        check("rst_post_grant", grant_id, 1'b0);
        check("rst_post_paddr", PADDR,    32'h700);
        tick;
        tick;
        check("rst_post_first_done", HREADYOUT, 2'b01);
        tick;
        check("rst_post_second_paddr", PADDR, 32'h800);
        tick;
        tick;
        check("rst_post_second_done", HREADYOUT, 2'b11);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

`default_nettype wire
